// File: rtl/ahb_write_master.sv
// AHB-Lite single-transfer write initiator: command FIFO feeding pipelined NONSEQ writes.
// Optional `AHB_WM_ERR_ABORT_EN: drop the cancelled transfer and flush the queue on ERROR.
module ahb_write_master #(
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            a_valid_q, a_valid_d;
    cmd_t            a_q, a_d;
    logic            d_valid_q, d_valid_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic            e1_q, e1_d;
    logic            err_q, err_d;

    logic fifo_empty, push, fifo_wr, pop, a_load, flush, nonseq;

    always_comb begin
        fifo_empty = (cnt_q == '0);
`ifdef AHB_WM_ERR_ABORT_EN
        cmd_ready = (cnt_q != Full) && !hresp && !e1_q;
        a_load    = hready && !e1_q;
        flush     = hready && e1_q;
`else
        cmd_ready = (cnt_q != Full);
        // A cancelled entry stays put through E2 so it is re-issued afterwards.
        a_load    = hready && !(e1_q && a_valid_q);
        flush     = 1'b0;
`endif
        push    = cmd_valid && cmd_ready;
        pop     = a_load && !fifo_empty;
        // An empty FIFO with A refilling lets the command bypass straight into A.
        fifo_wr = push && !(a_load && fifo_empty);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        a_valid_d = a_valid_q;
        a_d       = a_q;
        d_valid_d = d_valid_q;
        hwdata_d  = hwdata_q;
        e1_d      = e1_q;
        err_d     = err_q;

        if (fifo_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d = cnt_q + CntW'(fifo_wr) - CntW'(pop);

        if (flush) begin
            a_valid_d = 1'b0;
            cnt_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else if (a_load) begin
            a_valid_d = !fifo_empty || push;
            if (!fifo_empty) begin
                a_d = mem_q[rd_ptr_q];
            end else if (push) begin
                a_d = cmd_t'({cmd_addr, cmd_data});
            end
        end

        if (hready) begin
            if (e1_q) begin
                d_valid_d = 1'b0;
            end else begin
                d_valid_d = a_valid_q;
                if (a_valid_q) hwdata_d = a_q.data;
            end
        end

        e1_d = hready ? 1'b0 : (e1_q || hresp);

        if (hresp && hready) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            a_valid_q <= 1'b0;
            a_q       <= '0;
            d_valid_q <= 1'b0;
            hwdata_q  <= '0;
            e1_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            a_valid_q <= a_valid_d;
            a_q       <= a_d;
            d_valid_q <= d_valid_d;
            hwdata_q  <= hwdata_d;
            e1_q      <= e1_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= cmd_t'({cmd_addr, cmd_data});
    end

    always_comb begin
        nonseq = a_valid_q && !e1_q;
        htrans = nonseq ? 2'b10 : 2'b00;
        hsel   = nonseq;
        hwrite = nonseq;
        haddr  = a_q.addr;
        hwdata = hwdata_q;
        busy   = !fifo_empty || a_valid_q || d_valid_q;
        err    = err_q;
    end

endmodule

// File: tb/tb_ahb_write_master.sv
// Directed and randomized bench for ahb_write_master; a bus-level slave model logs completed
// writes and compares them with the accepted command stream.
module tb_ahb_write_master;

    logic       hclk, hreset_n, cmd_valid, cmd_ready, hsel, hwrite, hready, hresp;
    logic       busy, err, err_clr;
    logic [1:0] cmd_addr, haddr, htrans;
    logic [7:0] cmd_data, hwdata;

    int n_checks, n_fail;

    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } xfer_t;

    xfer_t      cmd_q[$];
    xfer_t      wr_q[$];
    logic [7:0] slv_reg [4];
    logic [7:0] exp_reg [4];
    logic       dp_v = 1'b0;
    logic [1:0] dp_a = 2'b00;

    ahb_write_master #(.ADDR_W(2), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .hclk(hclk), .hreset_n(hreset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .busy(busy), .err(err), .err_clr(err_clr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Slave-side view: inputs change just after posedge, so the negedge sees what the next
    // rising edge will commit.
    always @(negedge hclk) begin
        if (!hreset_n) begin
            dp_v = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) cmd_q.push_back({cmd_addr, cmd_data});
            if (hready) begin
                if (dp_v && !hresp) begin
                    wr_q.push_back({dp_a, hwdata});
                    slv_reg[dp_a] = hwdata;
                end
                dp_v = (htrans == 2'b10);
                dp_a = haddr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic neg();
        @(negedge hclk);
    endtask

    task automatic send(input logic [1:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    task automatic drain(input string tag);
        cmd_valid = 1'b0;
        hready    = 1'b1;
        hresp     = 1'b0;
        for (int n = 0; n < 60 && busy; n++) cyc();
        chk({tag, "_drain_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_len"}, 32'(wr_q.size()), 32'(cmd_q.size()));
        for (int i = 0; i < cmd_q.size() && i < wr_q.size(); i++)
            chk({tag, "_xfer"}, 32'(wr_q[i]), 32'(cmd_q[i]));
        cmd_q.delete();
        wr_q.delete();
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] a, input logic [7:0] d);
        chk({tag, "_htrans"}, 32'(htrans), 32'd2);
        chk({tag, "_haddr"}, 32'(haddr), 32'(a));
        chk({tag, "_hwdata"}, 32'(hwdata), 32'(d));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) slv_reg[i] = 8'h00;
        hreset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_data = 8'h00;
        hready = 1'b1; hresp = 1'b0; err_clr = 1'b0;

        // Reset values
        cyc(); cyc(); neg();
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_hsel", 32'(hsel), 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_haddr", 32'(haddr), 32'd0);
        chk("rst_hwdata", 32'(hwdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cyc(); hreset_n = 1'b1;
        cyc();

        // Single command: NONSEQ next cycle, data phase after, idle after that
        send(2'd2, 8'h15); neg();
        chk("t1_ready", 32'(cmd_ready), 32'd1);
        cyc(); cmd_valid = 1'b0; neg();
        chk("t1_htrans", 32'(htrans), 32'd2);
        chk("t1_haddr", 32'(haddr), 32'd2);
        chk("t1_hsel", 32'(hsel), 32'd1);
        chk("t1_hwrite", 32'(hwrite), 32'd1);
        cyc(); neg();
        chk("t1_hwdata", 32'(hwdata), 32'h15);
        chk("t1_idle", 32'(htrans), 32'd0);
        chk("t1_busy_dp", 32'(busy), 32'd1);
        cyc(); neg();
        chk("t1_busy_low", 32'(busy), 32'd0);
        compare_logs("t1");

        // Back-to-back commands at full throughput
        cyc(); send(2'd0, 8'hA1); neg();
        cyc(); send(2'd1, 8'hB2); neg();
        chk("t2_c1_htrans", 32'(htrans), 32'd2);
        chk("t2_c1_haddr", 32'(haddr), 32'd0);
        cyc(); send(2'd2, 8'h03); neg();
        chk_bus("t2_c2", 2'd1, 8'hA1);
        cyc(); cmd_valid = 1'b0; neg();
        chk_bus("t2_c3", 2'd2, 8'hB2);
        cyc(); neg();
        chk("t2_c4_idle", 32'(htrans), 32'd0);
        chk("t2_c4_hwdata", 32'(hwdata), 32'h03);
        cyc(); neg();
        chk("t2_busy_low", 32'(busy), 32'd0);
        chk("t2_payload_0", 32'(slv_reg[0]), 32'hA1);
        chk("t2_payload_1", 32'(slv_reg[1]), 32'hB2);
        chk("t2_data_size", 32'(slv_reg[2]), 32'h03);
        compare_logs("t2");

        // Two wait states during the data phase of the 2nd transfer
        cyc(); send(2'd0, 8'h11); neg();
        cyc(); send(2'd1, 8'h22); neg();
        cyc(); send(2'd2, 8'h33); neg();
        chk_bus("t3_pre", 2'd1, 8'h11);
        cyc(); cmd_valid = 1'b0; hready = 1'b0; neg();
        chk_bus("t3_wait0", 2'd2, 8'h22);
        cyc(); neg();
        chk_bus("t3_wait1", 2'd2, 8'h22);
        cyc(); hready = 1'b1; neg();
        chk_bus("t3_release", 2'd2, 8'h22);
        cyc(); neg();
        chk("t3_last_idle", 32'(htrans), 32'd0);
        chk("t3_last_hwdata", 32'(hwdata), 32'h33);
        chk("t3_last_busy", 32'(busy), 32'd1);
        cyc(); neg();
        chk("t3_busy_low", 32'(busy), 32'd0);
        compare_logs("t3");

        // Fill the FIFO while the bus is stalled
        cyc(); hready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2'(i % 3), 8'h40 + 8'(i)); neg();
            chk("t4_fill_ready", 32'(cmd_ready), 32'd1);
            cyc();
        end
        send(2'd1, 8'h44); neg();
        chk("t4_full_ready", 32'(cmd_ready), 32'd0);
        cyc(); neg();
        chk("t4_full_hold", 32'(cmd_ready), 32'd0);
        chk("t4_no_issue", 32'(htrans), 32'd0);
        cyc(); hready = 1'b1; neg();
        chk("t4_pop_edge", 32'(cmd_ready), 32'd0);
        cyc(); neg();
        chk("t4_after_pop", 32'(cmd_ready), 32'd1);
        chk("t4_first_htrans", 32'(htrans), 32'd2);
        chk("t4_first_haddr", 32'(haddr), 32'd0);
        cyc();
        drain("t4");
        compare_logs("t4");

        // ERROR response on the first of three queued transfers
        cyc(); hready = 1'b0; send(2'd0, 8'hC1); neg();
        cyc(); send(2'd1, 8'hC2); neg();
        cyc(); send(2'd2, 8'hC3); neg();
        cyc(); cmd_valid = 1'b0; hready = 1'b1; neg();
        cyc(); neg();
        chk("t5_first_htrans", 32'(htrans), 32'd2);
        chk("t5_first_haddr", 32'(haddr), 32'd0);
        cyc(); hresp = 1'b1; hready = 1'b0; neg();
        chk("t5_e1_htrans", 32'(htrans), 32'd2);
        chk("t5_e1_haddr", 32'(haddr), 32'd1);
        cyc(); hready = 1'b1; neg();
        chk("t5_e2_idle", 32'(htrans), 32'd0);
        chk("t5_e2_err", 32'(err), 32'd0);
        cyc(); hresp = 1'b0; neg();
        chk("t5_err_set", 32'(err), 32'd1);
`ifdef AHB_WM_ERR_ABORT_EN
        chk("t5_abort_idle", 32'(htrans), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_ready", 32'(cmd_ready), 32'd1);
        cyc(); neg();
        chk("t5_abort_still_idle", 32'(htrans), 32'd0);
`else
        chk("t5_reissue_htrans", 32'(htrans), 32'd2);
        chk("t5_reissue_haddr", 32'(haddr), 32'd1);
        cyc(); neg();
        chk_bus("t5_third", 2'd2, 8'hC2);
        cyc(); neg();
        chk("t5_last_hwdata", 32'(hwdata), 32'hC3);
        chk("t5_last_idle", 32'(htrans), 32'd0);
        cyc(); neg();
        chk("t5_busy_low", 32'(busy), 32'd0);
        chk("t5_payload_1", 32'(slv_reg[1]), 32'hC2);
        chk("t5_data_size", 32'(slv_reg[2]), 32'hC3);
`endif
        chk("t5_payload_0_untouched", 32'(slv_reg[0]), 32'h43);
        cmd_q.delete();
        wr_q.delete();

        cyc(); err_clr = 1'b1; neg();
        chk("t5_clr_same_cycle", 32'(err), 32'd1);
        cyc(); err_clr = 1'b0; neg();
        chk("t5_cleared", 32'(err), 32'd0);

        // Lone ERROR with hready high, coinciding with err_clr: set wins
        cyc(); hresp = 1'b1; err_clr = 1'b1; neg();
        cyc(); hresp = 1'b0; err_clr = 1'b0; neg();
        chk("t5_lone_set_wins", 32'(err), 32'd1);
        cyc(); err_clr = 1'b1; neg();
        cyc(); err_clr = 1'b0; neg();
        chk("t5_lone_cleared", 32'(err), 32'd0);

        // Reset pulsed mid-burst
        cyc(); send(2'd0, 8'h51); neg();
        cyc(); send(2'd1, 8'h52); neg();
        cyc(); send(2'd2, 8'h53); neg();
        cyc(); cmd_valid = 1'b0;
        chk("t6_pre_htrans", 32'(htrans), 32'd2);
        hreset_n = 1'b0;
        #1;
        chk("t6_async_htrans", 32'(htrans), 32'd0);
        chk("t6_async_hsel", 32'(hsel), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        cyc(); cyc(); hreset_n = 1'b1; neg();
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("t6_post_ready", 32'(cmd_ready), 32'd1);
        chk("t6_post_htrans", 32'(htrans), 32'd0);
        cmd_q.delete();
        wr_q.delete();

        // Random traffic with random wait states
        for (int i = 0; i < 4; i++) exp_reg[i] = slv_reg[i];
        for (int i = 0; i < 400; i++) begin
            cyc();
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr  = 2'($urandom_range(0, 2));
            cmd_data  = 8'($urandom);
            hready    = ($urandom_range(0, 3) != 0);
        end
        cyc();
        drain("t7");
        foreach (cmd_q[i]) exp_reg[cmd_q[i].a] = cmd_q[i].d;
        chk("t7_some_traffic", 32'(cmd_q.size() > 50), 32'd1);
        compare_logs("t7");
        for (int i = 0; i < 3; i++) chk("t7_reg", 32'(slv_reg[i]), 32'(exp_reg[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_write_master.md
# ahb_write_master

Single-master AHB-Lite write initiator sitting directly upstream of the AHB write slave register block (payload_0, payload_1, data_size). Accepts write commands from local logic over a valid/ready port, buffers them in a small FIFO, and issues them as pipelined NONSEQ single write transfers. Honours hready wait states and the two-cycle hresp error response, and reports errors through a sticky flag.

## Interface
- ADDR_W, 2, address width; carries the slave's write_select (0 = payload_0, 1 = payload_1, 2 = data_size)
- DATA_W, 8, write data width
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥ 2
- hclk  in  1  AHB clock; all logic on rising edge
- hreset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_addr  in  ADDR_W  target register select
- cmd_data  in  DATA_W  write data
- hsel  out  1  slave select; high whenever htrans = NONSEQ
- haddr  out  ADDR_W  address-phase address
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ; no other encodings driven
- hwrite  out  1  high with every NONSEQ
- hwdata  out  DATA_W  data-phase write data
- hready  in  1  transfer-complete / phase-advance
- hresp  in  1  0 OKAY, 1 ERROR
- busy  out  1  FIFO non-empty or any phase in flight
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation
- Reset values: htrans 00, hsel 0, hwrite 0, haddr 0, hwdata 0, err 0, busy 0, cmd_ready 1, FIFO empty.
- FIFO: push on cmd_valid & cmd_ready; cmd_ready = !full from the registered count. No push when full, even if a pop occurs in the same cycle.
- Two pipeline registers: address phase (A) and data phase (D), each with a valid bit.
- State per cycle, evaluated on hready:
  - hready = 1: A moves to D (hwdata loaded from A's data); FIFO head pops into A if non-empty, otherwise A becomes invalid (htrans IDLE).
  - hready = 0: A, D, haddr, htrans, hwdata held stable.
- Outputs: htrans/haddr/hsel/hwrite reflect A; hwdata reflects D. When D is invalid, hwdata holds its last value.
- Error handling, two-cycle sequence:
  - Cycle E1: hresp = 1, hready = 0. A is driven to IDLE for the next cycle; the cancelled A entry is retained internally.
  - Cycle E2: hresp = 1, hready = 1. D retires; err is set.
- err_clr clears err; a simultaneous set wins.
- hresp = 1 with hready = 1 without a preceding E1 is also treated as an error: err is set.

## Timing
- Command accepted at edge N → NONSEQ on the bus in cycle N+1 (FIFO empty, bus idle) → data phase in cycle N+2.
- Sustained throughput: one transfer per cycle with hready = 1.
- Each hready = 0 cycle adds exactly one cycle to the transfer in its data phase.
- busy falls the cycle after the last data phase completes with hready = 1.
- Reset asserted mid-transfer: all outputs return to reset values immediately and FIFO contents are discarded.

## Configuration
- AHB_WM_ERR_ABORT_EN defined: on E2, the cancelled A entry and all FIFO contents are discarded; the bus stays IDLE until a new command arrives. cmd_ready is forced low during E1/E2.
- AHB_WM_ERR_ABORT_EN undefined: the cancelled A entry is re-issued as NONSEQ in the cycle after E2, and the queue continues normally. Only err records the failure.

## Test plan
- Reset then single command (addr 2, data 8'h15) → NONSEQ haddr=2 in cycle 1; hwdata=8'h15 in cycle 2; busy low in cycle 3.
- Three back-to-back commands (0/8'hA1, 1/8'hB2, 2/8'h03) with hready = 1 → three consecutive NONSEQ cycles with hwdata lagging one cycle; slave model ends with payload_0=A1, payload_1=B2, data_size=3.
- hready low for 2 cycles during the data phase of the 2nd transfer → haddr, htrans and hwdata held stable for those cycles; total completion 2 cycles later.
- Push 5 commands with no drain (hready = 0 held) and FIFO_DEPTH = 4 → cmd_ready low after the FIFO fills; 5th command is not accepted until the first pop.
- ERROR on the 1st of 3 queued transfers → E1 drives IDLE, err = 1 after E2. With the macro: no further NONSEQ. Without the macro: transfers 2 and 3 are completed. err_clr then clears err.
- hreset_n pulsed low mid-burst → htrans = 00 asynchronously; after release, busy = 0 and cmd_ready = 1.
